// File: rtl/uart_runner_pkg.sv
// Shared opcodes, parser state encoding and baud divisor helper for the UART command runner.
package uart_runner_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  typedef enum logic [2:0] {
    ST_OPCODE, ST_RESERVED, ST_LEN_LSB, ST_LEN_MSB, ST_PAYLOAD, ST_COMPUTE, ST_SEND
  } state_e;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_runner_if.sv
// Byte stream with valid/ready handshake; a byte moves on a clock edge where both are high.
interface uart_runner_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_alu_parser.sv
// Packet parser: header decode, ECHO forwarding, ADD/MUL accumulation, restoring DIV and 4-byte result send.
module uart_alu_parser import uart_runner_pkg::*; (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_runner_if.slave  rx,
  uart_runner_if.master tx
);
  state_e      state, state_nxt;
  logic [7:0]  opcode, hold;
  logic        hold_vld;
  logic [15:0] len, cnt;
  logic [31:0] word, word_nxt, acc, dvd, dvs, quo, rem, result;
  logic [31:0] quo_nxt, rem_nxt;
  logic [32:0] rem_sh, diff;
  logic [1:0]  wcnt, send_idx;
  logic [5:0]  div_cnt;
  logic        rx_fire, tx_fire, last_byte, word_done, is_echo, is_alu, pl_done;

  assign rx.ready  = 1'b1;
  assign rx_fire   = rx.valid;
  assign tx.valid  = (state == ST_SEND) || hold_vld;
  assign tx.data   = (state == ST_SEND) ? result[{send_idx, 3'b000} +: 8] : hold;
  assign tx_fire   = tx.valid && tx.ready;
  assign is_echo   = (opcode == OP_ECHO);
  assign is_alu    = (opcode inside {OP_ADD, OP_MUL, OP_DIV});
  assign last_byte = (cnt == len - 16'd1);
  assign word_done = last_byte || (cnt[1:0] == 2'd3);
  assign pl_done   = (cnt == len);

  // Lane 0 starts a fresh word so a short final word is zero-extended.
  always_comb begin
    word_nxt = (cnt[1:0] == 2'd0) ? '0 : word;
    word_nxt[{cnt[1:0], 3'b000} +: 8] = rx.data;
  end

  // One restoring-division step: the borrow bit of diff decides subtract vs keep.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_nxt = {quo[30:0], ~diff[32]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OPCODE:   if (rx_fire) state_nxt = ST_RESERVED;
      ST_RESERVED: if (rx_fire) state_nxt = ST_LEN_LSB;
      ST_LEN_LSB:  if (rx_fire) state_nxt = ST_LEN_MSB;
      ST_LEN_MSB:  if (rx_fire) state_nxt = ({rx.data, len[7:0]} == 16'd0) ? ST_COMPUTE : ST_PAYLOAD;
      ST_PAYLOAD:  if (pl_done && (!hold_vld || tx.ready))
                     state_nxt = is_alu ? ST_COMPUTE : ST_OPCODE;
      ST_COMPUTE:  if (!is_alu) state_nxt = ST_OPCODE;
                   else if (opcode != OP_DIV || div_cnt == 6'd32) state_nxt = ST_SEND;
      ST_SEND:     if (tx.ready && send_idx == 2'd3) state_nxt = ST_OPCODE;
      default:     state_nxt = ST_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_OPCODE;
      opcode   <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      len      <= '0;
      cnt      <= '0;
      word     <= '0;
      acc      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      result   <= '0;
      wcnt     <= '0;
      send_idx <= '0;
      div_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (tx_fire && state != ST_SEND) hold_vld <= 1'b0;
      if (state != ST_COMPUTE) div_cnt <= '0;
      if (state != ST_SEND) send_idx <= '0;
      case (state)
        ST_OPCODE: if (rx_fire) begin
          opcode <= rx.data;
          acc    <= (rx.data == OP_MUL) ? 32'd1 : 32'd0;
          dvd    <= '0;
          dvs    <= '0;
          wcnt   <= '0;
          cnt    <= '0;
        end
        ST_LEN_LSB: if (rx_fire) len[7:0]  <= rx.data;
        ST_LEN_MSB: if (rx_fire) len[15:8] <= rx.data;
        ST_PAYLOAD: if (rx_fire && !pl_done) begin
          cnt  <= cnt + 16'd1;
          word <= word_nxt;
          if (is_echo) begin
            hold     <= rx.data;
            hold_vld <= 1'b1;
          end
          if (word_done) begin
            case (opcode)
              OP_ADD: acc <= acc + word_nxt;
              OP_MUL: acc <= acc * word_nxt;
              OP_DIV: begin
                if (wcnt == 2'd0) dvd <= word_nxt;
                if (wcnt == 2'd1) dvs <= word_nxt;
                if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
              end
              default: ;
            endcase
          end
        end
        ST_COMPUTE: begin
          div_cnt <= div_cnt + 6'd1;
          if (opcode != OP_DIV) begin
            result <= acc;
          end else if (div_cnt == 6'd0) begin
            rem <= '0;
            quo <= dvd;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (div_cnt == 6'd32)
              result <= (len == 16'd0) ? 32'd0 : (dvs == 32'd0) ? 32'hFFFF_FFFF : quo_nxt;
          end
        end
        ST_SEND: if (tx.ready) send_idx <= send_idx + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: finds the start edge, samples each bit mid-cell, emits a byte when the stop bit is high.
module uart_rx import uart_runner_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rxd_i,
  uart_runner_if.master m
);
  localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(DIV / 2);

  logic [1:0]    sync;
  logic          busy;
  logic [CW-1:0] tick;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rxd_s;

  assign rxd_s = sync[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync    <= 2'b11;
      busy    <= 1'b0;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      m.valid <= 1'b0;
      m.data  <= '0;
    end else begin
      sync <= {sync[0], rxd_i};
      if (m.valid && m.ready) m.valid <= 1'b0;
      if (!busy) begin
        if (!rxd_s) begin
          busy    <= 1'b1;
          tick    <= HALF;
          bit_idx <= '0;
        end
      end else if (tick != '0) begin
        tick <= tick - CW'(1);
      end else begin
        tick <= DIV_M1;
        // bit_idx 0 re-checks the start bit mid-cell to reject glitches
        if (bit_idx == 4'd0) begin
          if (rxd_s) busy <= 1'b0;
          else       bit_idx <= 4'd1;
        end else if (bit_idx <= 4'd8) begin
          shreg   <= {rxd_s, shreg[7:1]};
          bit_idx <= bit_idx + 4'd1;
        end else begin
          busy <= 1'b0;
          if (rxd_s) begin
            m.data  <= shreg;
            m.valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; ready rises in the last cycle of the stop bit so frames can run back to back.
module uart_tx import uart_runner_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic         clk_i,
  input  logic         rst_i,
  uart_runner_if.slave s,
  output logic         txd_o
);
  localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic          busy;
  logic [CW-1:0] tick;
  logic [3:0]    nbits;
  logic [9:0]    shreg;
  logic          done;

  assign done    = busy && (nbits == 4'd1) && (tick == '0);
  assign s.ready = !busy || done;
  assign txd_o   = busy ? shreg[0] : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy  <= 1'b0;
      tick  <= '0;
      nbits <= '0;
      shreg <= '1;
    end else if (s.valid && s.ready) begin
      busy  <= 1'b1;
      tick  <= DIV_M1;
      nbits <= 4'd10;
      shreg <= {1'b1, s.data, 1'b0};
    end else if (busy) begin
      if (tick != '0) begin
        tick <= tick - CW'(1);
      end else begin
        tick  <= DIV_M1;
        shreg <= {1'b1, shreg[9:1]};
        nbits <= nbits - 4'd1;
        if (nbits == 4'd1) busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/uart_runner.sv
// UART command processor top: serial RX -> packet parser/ALU -> serial TX.
module uart_runner #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic txd_o
);
  uart_runner_if rx_s ();
  uart_runner_if tx_s ();

  uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rxd_i (rxd_i),
    .m     (rx_s.master)
  );

  uart_alu_parser u_parser (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx    (rx_s.slave),
    .tx    (tx_s.master)
  );

  uart_tx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .s     (tx_s.slave),
    .txd_o (txd_o)
  );
endmodule

// File: tb/tb_uart_runner.sv
// Serial-level bench: drives framed packets, decodes txd_o independently, checks against a queued model.
module tb_uart_runner;
  import uart_runner_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int BIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  always #5 clk = ~clk;

  uart_runner_if mon ();

  uart_runner #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rxd_i (rxd),
    .txd_o (txd)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_tx  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [7:0] op, input int len, input logic [127:0] v);
    logic [31:0] r, w, a, b;
    int nw;
    nw = (len + 3) / 4;
    r  = (op == OP_MUL) ? 32'd1 : 32'd0;
    a  = 0;
    b  = 0;
    for (int k = 0; k < nw; k++) begin
      w = v[32*k +: 32];
      for (int j = 0; j < 4; j++) if (4*k + j >= len) w[8*j +: 8] = 8'h00;
      if (op == OP_ADD) r = r + w;
      else if (op == OP_MUL) r = r * w;
      else if (k == 0) a = w;
      else if (k == 1) b = w;
    end
    if (op == OP_DIV) r = (len == 0) ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  // Payload byte i is v[8i+7:8i]; expected response bytes are queued before the packet goes out.
  task automatic send_pkt(input logic [7:0] op, input int len, input logic [127:0] v);
    logic [31:0] r;
    logic [15:0] l;
    l = 16'(len);
    if (op == OP_ECHO) begin
      for (int i = 0; i < len; i++) exp_q.push_back(v[8*i +: 8]);
    end else if (op inside {OP_ADD, OP_MUL, OP_DIV}) begin
      r = alu_model(op, len, v);
      for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
    end
    send_byte(op);
    send_byte(8'h5A);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    for (int i = 0; i < len; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (30 * BIT) @(negedge clk);
  endtask

  // Independent 8N1 decoder on txd_o.
  initial begin
    mon.valid = 1'b0;
    mon.data  = 8'h00;
    mon.ready = 1'b1;
    mon_b     = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        chk("start_bit", {31'b0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        chk("stop_bit", {31'b0, txd}, 32'd1);
        n_tx++;
        mon.data  = mon_b;
        mon.valid = 1'b1;
        @(negedge clk);
        mon.valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (mon.valid && mon.ready) begin
      if (exp_q.size() == 0) chk("extra_byte", {24'b0, mon.data}, 32'h100);
      else                   chk("tx_byte", {24'b0, mon.data}, {24'b0, exp_q.pop_front()});
    end
  end

  initial begin
    int lowc, base;
    repeat (5) @(negedge clk);
    chk("rst_txd", {31'b0, txd}, 32'd1);
    rst = 1'b0;
    lowc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lowc++;
    end
    chk("idle_txd_low", 32'(lowc), 32'd0);
    chk("idle_bytes", 32'(n_tx), 32'd0);

    send_pkt(OP_ECHO, 5, 128'h55_44_33_22_11);                  drain("echo5");
    send_pkt(OP_ADD, 8, 128'h00000002_00000001);                drain("add_1_2");
    send_pkt(OP_ADD, 6, 128'h0001_FFFFFFFF);                    drain("add_wrap");
    send_pkt(OP_MUL, 12, 128'h00000007_00000005_00000003);      drain("mul_3_5_7");
    send_pkt(OP_MUL, 3, 128'h01_00_02);                         drain("mul_partial");
    send_pkt(OP_DIV, 8, 128'h00000007_00000064);                drain("div_100_7");
    send_pkt(OP_DIV, 8, 128'h00000001_DEADBEEF);                drain("div_by_1");
    send_pkt(OP_DIV, 8, 128'h00000000_00000005);                drain("div_by_0");
    send_pkt(OP_DIV, 12, 128'h00000009_00000007_00000064);      drain("div_extra");
    send_pkt(OP_DIV, 4, 128'h00000064);                         drain("div_one_word");
    send_pkt(OP_ADD, 0, 128'h0);                                drain("add_len0");
    send_pkt(OP_MUL, 0, 128'h0);                                drain("mul_len0");
    send_pkt(OP_DIV, 0, 128'h0);                                drain("div_len0");
    send_pkt(OP_MUL, 8, 128'h00010001_FFFF0003);                drain("mul_trunc");

    base = n_tx;
    send_pkt(OP_ECHO, 0, 128'h0);
    drain("echo_len0");
    chk("echo_len0_silent", 32'(n_tx - base), 32'd0);

    base = n_tx;
    send_pkt(8'h55, 4, 128'hDD_CC_BB_AA);
    drain("unk_op");
    chk("unk_op_silent", 32'(n_tx - base), 32'd0);
    send_pkt(OP_ADD, 8, 128'h00000020_00000010);                drain("add_after_unk");

    base = n_tx;
    send_byte(OP_ADD);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50 * BIT) @(negedge clk);
    chk("rst_abort_silent", 32'(n_tx - base), 32'd0);
    send_pkt(OP_ADD, 8, 128'h00000009_00000007);                drain("add_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
